saph_pixread_fb: RTL and testbench
==================================

// Module: saph_pixread_fb
// PURPOSE
//   Memory-side responder for saph_pixreadport (MEM modport): turns GPU pixel lookups (x,y) into
//   linear framebuffer reads on a fixed-latency synchronous SRAM port.
//   Unpacks the returned word into `color` and presents it on q_res at a fixed, parameter-derived latency.
//   Sits between the GPU pixel fetch logic and the framebuffer RAM arbiter.
// PARAMETERS
//   MEM_LAT  1   SRAM read latency in cycles, mem_re to mem_rdata valid; range 1..4
//   ADDR_W   24  word address width of the SRAM port
//   FMT      0   pixel format: 0 = ARGB8888 (1 px/word), 1 = RGB565 (2 px/word, x[0]=1 -> bits 31:16)
//   LATENCY  = MEM_LAT+2 (derived localparam); the pixreadport instance must be built with latency=LATENCY
// PORTS
//   clk         in   1       clock, all state on rising edge
//   rst_n       in   1       asynchronous active-low reset
//   port        MEM  -       saph_pixreadport.MEM: d_trig, d_x[13:0], d_y[13:0] in; d_ready, q_res out
//   cfg_base    in   ADDR_W  framebuffer base word address
//   cfg_stride  in   14      row pitch in pixels
//   cfg_width   in   14      visible width in pixels; x >= width is out of bounds
//   cfg_height  in   14      visible height in pixels; y >= height is out of bounds
//   cfg_border  in   color   value returned for out-of-bounds lookups
//   mem_re      out  1       SRAM read strobe
//   mem_addr    out  ADDR_W  SRAM word address
//   mem_ready   in   1       arbiter grants SRAM this cycle
//   mem_rdata   in   32      SRAM read data, valid MEM_LAT cycles after an accepted mem_re
//   q_valid     out  1       pulses high the cycle q_res takes a new value (observability, not part of the interface)
// BEHAVIOUR
//   - Reset: d_ready=0, mem_re=0, mem_addr=0, q_res=0, q_valid=0; all pipeline valid bits cleared.
//     Async assert; release is synchronised internally, d_ready rises at the earliest 1 cycle after release.
//   - d_ready = mem_ready & !in_reset (combinational); a lookup is accepted only when d_trig & d_ready.
//   - d_trig with d_ready=0 is ignored; nothing is queued and the GPU must retry.
//   - Stage A (accept cycle + 1): register pixel index idx = d_y*cfg_stride + d_x.
//     Product is 28 bits; the add is 29 bits.
//     Word offset = idx (FMT 0) or idx>>1 (FMT 1), added to cfg_base, truncated mod 2^ADDR_W.
//     Stage A also registers oob = (d_x>=cfg_width)|(d_y>=cfg_height) and, for FMT 1, the halfword select.
//     cfg_* inputs are sampled at accept only; later changes do not affect in-flight lookups.
//   - Stage A also drives mem_re=!oob and mem_addr for one cycle.
//     An oob lookup never asserts mem_re, and mem_addr holds its previous value.
//   - Delay line: MEM_LAT stages carry valid, oob, halfword select and border snapshot alongside the SRAM.
//   - Stage C: register q_res = oob ? border : unpack(mem_rdata, sel); pulse q_valid=1 for 1 cycle.
//     q_res holds its value until the next result.
//   - Latency: accept at cycle T -> q_res valid at T+LATENCY for every request, oob or not.
//   - Throughput 1 lookup/cycle; back-to-back accepts produce back-to-back results in order.
//   - mem_ready low after acceptance does not stall in-flight work; fixed SRAM latency is guaranteed by the arbiter.
//   - No buffering beyond the fixed pipe, so full/empty conditions cannot arise.
//   - Reset mid-operation: in-flight lookups are dropped, and no q_valid pulse occurs after reset release.
//   - Coordinates are unsigned; x=16383 or y=16383 with smaller cfg bounds is oob.
//     Address wrap at 2^ADDR_W is silent.
// STRUCTURE
//   - saph_defines.svh / package gains: typedef pixfmt_e {PIXFMT_ARGB8888, PIXFMT_RGB565};
//     function saph_unpack_pixel(logic[31:0] w, logic sel, pixfmt_e f) -> color.
//     RGB565 expands by bit replication with alpha forced to max; ARGB8888 maps fields directly.
//   - One sub-module, saph_delay_pipe #(WIDTH, DEPTH): reset-clearable shift register for the side-band fields.
// TESTING
//   1. Reset: hold rst_n=0 with d_trig=1 and mem_ready=1 -> d_ready=0, mem_re=0, q_valid=0 throughout;
//      d_ready=1 one cycle after release.
//   2. ARGB8888, base=0x1000, stride=640, (x,y)=(3,2), mem_rdata=0x80FF4020 ->
//      mem_addr=0x1503 at T+1; q_res equals the unpacked 0x80FF4020 at T+LATENCY.
//   3. RGB565, base=0, stride=320, (5,1) -> mem_addr=162, upper half used;
//      rdata=0xF800_0000 -> q_res red=max, green=0, blue=0, alpha=max.
//   4. OOB: width=640, (640,0) -> no mem_re; q_res=cfg_border at T+LATENCY.
//   5. Streaming: 8 consecutive accepts, including an oob lookup at accept 3 and mem_ready=0 at cycle 4 ->
//      d_ready=0 that cycle and that lookup is not accepted;
//      results arrive in order with exactly LATENCY spacing from their accepts.
//   6. Assert rst_n=0 with 3 lookups in flight -> q_valid stays 0 after release until a new accept + LATENCY.
//      Repeat scenarios 2-5 for MEM_LAT=1 and MEM_LAT=3.

Source files
------------

// File: rtl/saph_pixread_fb_pkg.sv
// Shared types for the pixel-read framebuffer responder: pixel formats,
// the colour record, and the word-to-colour unpack helper.
package saph_pixread_fb_pkg;

  typedef enum logic {
    PIXFMT_ARGB8888 = 1'b0,
    PIXFMT_RGB565   = 1'b1
  } pixfmt_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } color_t;

  localparam int COORD_W = 14;
  localparam int COLOR_W = 32;

  // RGB565 widens each field by replicating its top bits so full scale maps
  // to 0xFF; alpha is forced opaque. ARGB8888 maps the word straight across.
  function automatic color_t saph_unpack_pixel(logic [31:0] w, logic sel, pixfmt_e f);
    color_t     c;
    logic [15:0] h;
    h = sel ? w[31:16] : w[15:0];
    if (f == PIXFMT_RGB565) begin
      c.a = 8'hFF;
      c.r = {h[15:11], h[15:13]};
      c.g = {h[10:5],  h[10:9]};
      c.b = {h[4:0],   h[4:2]};
    end else begin
      c = color_t'(w);
    end
    return c;
  endfunction

endpackage

// File: rtl/saph_delay_pipe.sv
// Reset-clearable fixed-depth shift register used to carry side-band fields
// alongside the SRAM read latency.
module saph_delay_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      // first stage captures the input
      always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_stage[g] <= '0;
        else          r_stage[g] <= i_d;
    end else begin : g_tail
      // subsequent stages shift the previous one
      always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_stage[g] <= '0;
        else          r_stage[g] <= r_stage[g-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/saph_pixread_fb.sv
// Memory-side responder for pixel lookups: (x,y) -> linear SRAM word read,
// then unpack to colour. Fixed latency MEM_LAT+2, one lookup per cycle.
module saph_pixread_fb
  import saph_pixread_fb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 24,
  parameter int FMT     = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // pixel lookup port
  input  logic              i_d_trig,
  input  logic [13:0]       i_d_x,
  input  logic [13:0]       i_d_y,
  output logic              o_d_ready,
  output logic [31:0]       o_q_res,
  output logic              o_q_valid,
  // configuration
  input  logic [ADDR_W-1:0] i_cfg_base,
  input  logic [13:0]       i_cfg_stride,
  input  logic [13:0]       i_cfg_width,
  input  logic [13:0]       i_cfg_height,
  input  logic [31:0]       i_cfg_border,
  // SRAM port
  output logic              o_mem_re,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ready,
  input  logic [31:0]       i_mem_rdata
);

  localparam int      LATENCY   = MEM_LAT + 2;
  localparam int      DLY_DEPTH = LATENCY - 2;
  localparam pixfmt_e PFMT      = (FMT == 1) ? PIXFMT_RGB565 : PIXFMT_ARGB8888;
  localparam int      SB_W      = 3 + COLOR_W;

  // Reset release is held off one edge so d_ready never rises in the
  // same cycle the async reset is removed.
  logic r_run;
  // run flag: low in reset, high from the first edge after release
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_run <= 1'b0;
    else          r_run <= 1'b1;

  logic w_acc;
  assign o_d_ready = i_mem_ready & r_run;
  assign w_acc     = i_d_trig & o_d_ready;

  // Address and bounds are formed from the live cfg in the accept cycle.
  logic [27:0]       w_prod;
  logic [28:0]       w_idx;
  logic [28:0]       w_off;
  logic [ADDR_W-1:0] w_addr;
  logic              w_oob;

  assign w_prod = 28'(i_d_y) * 28'(i_cfg_stride);
  assign w_idx  = 29'(w_prod) + 29'(i_d_x);
  assign w_off  = (PFMT == PIXFMT_RGB565) ? (w_idx >> 1) : w_idx;
  assign w_addr = i_cfg_base + ADDR_W'(w_off);
  assign w_oob  = (i_d_x >= i_cfg_width) | (i_d_y >= i_cfg_height);

  logic              r_a_vld, r_a_oob, r_a_sel, r_mem_re;
  logic [31:0]       r_a_border;
  logic [ADDR_W-1:0] r_mem_addr;

  // stage A: snapshot the lookup, issue the SRAM read for in-bounds pixels
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_a_vld    <= 1'b0;
      r_a_oob    <= 1'b0;
      r_a_sel    <= 1'b0;
      r_a_border <= '0;
      r_mem_re   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_a_vld  <= w_acc;
      r_mem_re <= w_acc & ~w_oob;
      if (w_acc) begin
        r_a_oob    <= w_oob;
        r_a_sel    <= i_d_x[0];
        r_a_border <= i_cfg_border;
      end
      if (w_acc & ~w_oob) r_mem_addr <= w_addr;
    end

  assign o_mem_re   = r_mem_re;
  assign o_mem_addr = r_mem_addr;

  // Side-band rides a delay line matched to the SRAM read latency.
  logic [SB_W-1:0] w_c_bus;
  logic            w_c_vld, w_c_oob, w_c_sel;
  logic [31:0]     w_c_border;

  saph_delay_pipe #(.WIDTH(SB_W), .DEPTH(DLY_DEPTH)) u_sb_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     ({r_a_vld, r_a_oob, r_a_sel, r_a_border}),
    .o_q     (w_c_bus)
  );

  assign {w_c_vld, w_c_oob, w_c_sel, w_c_border} = w_c_bus;

  color_t r_q_res;
  logic   r_q_valid;

  // stage C: pick border or unpacked SRAM word, hold until the next result
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_q_res   <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_q_valid <= w_c_vld;
      if (w_c_vld)
        r_q_res <= w_c_oob ? color_t'(w_c_border)
                           : saph_unpack_pixel(i_mem_rdata, w_c_sel, PFMT);
    end

  assign o_q_res   = r_q_res;
  assign o_q_valid = r_q_valid;

endmodule

// File: tb/tb_saph_pixread_fb.sv
// Bench for saph_pixread_fb: four instances (ARGB/RGB565 x MEM_LAT 1/3) share
// one stimulus stream; a queue-based reference model predicts every output.
module tb_saph_pixread_fb;

  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        d_trig = 1'b0;
  logic [13:0] d_x = '0, d_y = '0;
  logic [13:0] cfg_stride = 14'd640, cfg_width = 14'd640, cfg_height = 14'd480;
  logic [23:0] cfg_base = '0;
  logic [31:0] cfg_border = 32'h11223344;
  logic        mem_ready = 1'b0;

  logic        d_ready  [ND];
  logic        mem_re   [ND];
  logic        q_valid  [ND];
  logic [23:0] mem_addr [ND];
  logic [31:0] q_res    [ND];
  logic [31:0] rdata    [ND];

  int   cyc = 0;
  logic up = 1'b0;
  int   nvec = 0, nmis = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) up <= rst_n;

  // SRAM contents: a few hand-chosen words, otherwise a tagged address
  function automatic logic [31:0] memw(input logic [23:0] a);
    case (a)
      24'h001503: return 32'h80FF4020;
      24'h0000A2: return 32'hF8000000;
      24'h000200: return 32'h07E0001F;
      24'h000300: return 32'h00008410;
      default:    return {8'hA5, a};
    endcase
  endfunction

  function automatic int lat_of(input int k);
    return (k % 2 == 1) ? 5 : 3;
  endfunction

  function automatic int fmt_of(input int k);
    return k / 2;
  endfunction

  for (genvar k = 0; k < ND; k++) begin : g_dut
    localparam int ML = (k % 2 == 1) ? 3 : 1;
    localparam int FM = k / 2;
    logic [ML-1:0]       re_p = '0;
    logic [ML-1:0][23:0] ad_p = '0;

    always @(posedge clk) begin
      re_p[0] <= mem_re[k];
      ad_p[0] <= mem_addr[k];
      for (int i = 1; i < ML; i++) begin
        re_p[i] <= re_p[i-1];
        ad_p[i] <= ad_p[i-1];
      end
    end

    assign rdata[k] = re_p[ML-1] ? memw(ad_p[ML-1]) : 32'hDEADBEEF;

    saph_pixread_fb #(.MEM_LAT(ML), .ADDR_W(24), .FMT(FM)) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_d_trig     (d_trig),
      .i_d_x        (d_x),
      .i_d_y        (d_y),
      .o_d_ready    (d_ready[k]),
      .o_q_res      (q_res[k]),
      .o_q_valid    (q_valid[k]),
      .i_cfg_base   (cfg_base),
      .i_cfg_stride (cfg_stride),
      .i_cfg_width  (cfg_width),
      .i_cfg_height (cfg_height),
      .i_cfg_border (cfg_border),
      .o_mem_re     (mem_re[k]),
      .o_mem_addr   (mem_addr[k]),
      .i_mem_ready  (mem_ready),
      .i_mem_rdata  (rdata[k])
    );
  end

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, k, cyc, act, exp);
    end
  endtask

  // reference colour: RGB565 fields scaled by bit replication arithmetic
  function automatic logic [31:0] unpack_ref(input logic [31:0] w, input int sel, input int fmt);
    int h, r, g, b;
    if (fmt == 0) return w;
    h = sel ? int'(w >> 16) : int'(w & 32'hFFFF);
    r = (h >> 11) & 31;
    g = (h >> 5) & 63;
    b = h & 31;
    return 32'hFF000000 | 32'((r * 8 + r / 4) << 16) | 32'((g * 4 + g / 16) << 8) | 32'(b * 8 + b / 4);
  endfunction

  typedef struct {
    int          due;
    logic [31:0] v;
  } ev_t;

  ev_t         qq [ND][$];
  ev_t         qm [ND][$];
  logic [31:0] hq [ND];
  logic [23:0] ha [ND];

  task automatic model_accept();
    int          idx, off, addr;
    logic        oob;
    ev_t         e;
    idx = int'(d_y) * int'(cfg_stride) + int'(d_x);
    oob = (d_x >= cfg_width) || (d_y >= cfg_height);
    for (int k = 0; k < ND; k++) begin
      off  = (fmt_of(k) == 1) ? idx / 2 : idx;
      addr = (int'(cfg_base) + off) % (1 << 24);
      if (!oob) begin
        e.due = cyc + 1;
        e.v   = 32'(addr);
        qm[k].push_back(e);
      end
      e.due = cyc + lat_of(k);
      e.v   = oob ? cfg_border : unpack_ref(memw(24'(addr)), int'(d_x) % 2, fmt_of(k));
      qq[k].push_back(e);
    end
  endtask

  // cycle monitor: every output of every instance against the model
  always @(negedge clk) begin
    logic ev_q, ev_m, exp_rdy;
    exp_rdy = mem_ready && rst_n && up;
    for (int k = 0; k < ND; k++) begin
      if (!rst_n) begin
        qq[k].delete();
        qm[k].delete();
        hq[k] = '0;
        ha[k] = '0;
      end
      ev_q = 1'b0;
      if (qq[k].size() > 0 && qq[k][0].due == cyc) begin
        hq[k] = qq[k][0].v;
        void'(qq[k].pop_front());
        ev_q = 1'b1;
      end
      ev_m = 1'b0;
      if (qm[k].size() > 0 && qm[k][0].due == cyc) begin
        ha[k] = 24'(qm[k][0].v);
        void'(qm[k].pop_front());
        ev_m = 1'b1;
      end
      chk("q", k, 64'({q_valid[k], q_res[k]}), 64'({ev_q, hq[k]}));
      chk("mem", k, 64'({mem_re[k], mem_addr[k]}), 64'({ev_m, ha[k]}));
      chk("d_ready", k, 64'(d_ready[k]), 64'(exp_rdy));
    end
    if (d_trig && exp_rdy) model_accept();
  end

  typedef struct {
    logic [13:0] x, y, stride, width, height;
    logic [23:0] base;
    logic        oob;
    logic [23:0] a0, a1;
    logic [31:0] q0, q1;
    logic [1:0]  cq;
  } vec_t;

  vec_t tab [11];

  // single isolated lookup, checked directly against hand-computed values
  task automatic run_vec(input vec_t t);
    @(posedge clk); #1;
    d_x = t.x; d_y = t.y; cfg_stride = t.stride; cfg_width = t.width;
    cfg_height = t.height; cfg_base = t.base; cfg_border = 32'h11223344;
    mem_ready = 1'b1; d_trig = 1'b1;
    @(posedge clk); #1;
    d_trig = 1'b0;
    cfg_base = 24'h5A5A5A; cfg_border = 32'hCAFEF00D;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < ND; k++) begin
        if (c == 1) begin
          chk("tab_re", k, 64'(mem_re[k]), 64'(!t.oob));
          if (!t.oob) chk("tab_addr", k, 64'(mem_addr[k]), 64'((fmt_of(k) == 1) ? t.a1 : t.a0));
        end
        if (c == lat_of(k)) begin
          chk("tab_qv", k, 64'(q_valid[k]), 64'(1));
          if (t.cq[fmt_of(k)])
            chk("tab_q", k, 64'(q_res[k]), 64'((fmt_of(k) == 1) ? t.q1 : t.q0));
        end
      end
    end
  endtask

  initial begin
    tab[0]  = '{14'd3,     14'd2,     14'd640, 14'd640, 14'd480, 24'h001000, 1'b0, 24'h001503, 24'h001281, 32'h80FF4020, 32'h0,        2'b01};
    tab[1]  = '{14'd5,     14'd1,     14'd320, 14'd320, 14'd240, 24'h000000, 1'b0, 24'h000145, 24'h0000A2, 32'hA5000145, 32'hFFFF0000, 2'b11};
    tab[2]  = '{14'd640,   14'd0,     14'd640, 14'd640, 14'd480, 24'h001000, 1'b1, 24'h0,      24'h0,      32'h11223344, 32'h11223344, 2'b11};
    tab[3]  = '{14'd0,     14'd480,   14'd640, 14'd640, 14'd480, 24'h001000, 1'b1, 24'h0,      24'h0,      32'h11223344, 32'h11223344, 2'b11};
    tab[4]  = '{14'd16383, 14'd16383, 14'd640, 14'd640, 14'd480, 24'h001000, 1'b1, 24'h0,      24'h0,      32'h11223344, 32'h11223344, 2'b11};
    tab[5]  = '{14'd4,     14'd1,     14'd16,  14'd16,  14'd16,  24'hFFFFF0, 1'b0, 24'h000004, 24'hFFFFFA, 32'hA5000004, 32'hFFFFFFD6, 2'b11};
    tab[6]  = '{14'd639,   14'd479,   14'd640, 14'd640, 14'd480, 24'h000000, 1'b0, 24'h04AFFF, 24'h0257FF, 32'hA504AFFF, 32'h0,        2'b01};
    tab[7]  = '{14'd4,     14'd1,     14'd320, 14'd320, 14'd240, 24'h000000, 1'b0, 24'h000144, 24'h0000A2, 32'hA5000144, 32'hFF000000, 2'b11};
    tab[8]  = '{14'd1,     14'd0,     14'd2,   14'd2,   14'd2,   24'h000200, 1'b0, 24'h000201, 24'h000200, 32'hA5000201, 32'hFF00FF00, 2'b11};
    tab[9]  = '{14'd0,     14'd0,     14'd2,   14'd2,   14'd2,   24'h000200, 1'b0, 24'h000200, 24'h000200, 32'h07E0001F, 32'hFF0000FF, 2'b11};
    tab[10] = '{14'd0,     14'd0,     14'd2,   14'd2,   14'd2,   24'h000300, 1'b0, 24'h000300, 24'h000300, 32'h00008410, 32'hFF848284, 2'b11};

    // reset with trigger and ready held high
    #1;
    rst_n = 1'b0; d_trig = 1'b1; mem_ready = 1'b1; d_x = 14'd1; d_y = 14'd1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy0", 0, 64'(d_ready[0]), 64'(0));
    @(negedge clk);
    chk("rel_rdy1", 0, 64'(d_ready[0]), 64'(1));
    @(posedge clk); #1 d_trig = 1'b0;
    repeat (6) @(posedge clk);

    foreach (tab[i]) run_vec(tab[i]);

    // streaming: oob at accept 3, arbiter busy on attempt 5
    cfg_base = 24'h002000; cfg_stride = 14'd100; cfg_width = 14'd100; cfg_height = 14'd50;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      d_trig = 1'b1;
      d_x = (i == 2) ? 14'd100 : 14'(i * 7);
      d_y = 14'(i);
      mem_ready = (i != 4);
      cfg_border = 32'hB0000000 | 32'(i);
      @(negedge clk);
      chk("stream_rdy", 0, 64'(d_ready[0]), 64'(i != 4));
    end
    @(posedge clk); #1 d_trig = 1'b0; mem_ready = 1'b1;
    repeat (8) @(posedge clk);

    // reset with three lookups in flight
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      d_trig = 1'b1; d_x = 14'(i + 10); d_y = 14'd3;
    end
    @(posedge clk); #1 d_trig = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int k = 0; k < ND; k++) chk("no_qv_after_rst", k, 64'(q_valid[k]), 64'(0));
    end
    @(posedge clk); #1 d_trig = 1'b1; d_x = 14'd20; d_y = 14'd4;
    @(posedge clk); #1 d_trig = 1'b0;
    repeat (8) @(posedge clk);

    // randomized traffic with shifting configuration
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        @(posedge clk); #1;
        d_trig = 1'b0;
        cfg_width  = 14'($urandom_range(1, 700));
        cfg_height = 14'($urandom_range(1, 500));
        cfg_stride = cfg_width + 14'($urandom_range(0, 16));
        cfg_base   = 24'($urandom());
      end
      @(posedge clk); #1;
      d_trig    = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) d_x = 14'($urandom_range(0, 16383));
      else                           d_x = 14'($urandom_range(0, int'(cfg_width) + 2));
      if ($urandom_range(0, 9) == 0) d_y = 14'($urandom_range(0, 16383));
      else                           d_y = 14'($urandom_range(0, int'(cfg_height) + 2));
      if ($urandom_range(0, 9) == 0) cfg_border = $urandom();
    end
    @(posedge clk); #1 d_trig = 1'b0;
    repeat (10) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
